// File: rtl/sqrt_param_if.sv
// sqrt_param_if -- request/result bundle for the sqrt_param engine.
//   start      : request a calculation (master -> slave)
//   val        : unsigned radicand, WIDTH bits (master -> slave)
//   ceil_mode  : 0 = floor, 1 = ceiling rounding (master -> slave)
//   busy       : calculation in progress (slave -> master)
//   out        : rounded root, WIDTH/2+1 bits (slave -> master)
//   rem        : val minus floor root squared, WIDTH/2+1 bits (slave -> master)
//   eop        : one-cycle pulse, out/rem valid (slave -> master)
interface sqrt_param_if #(
   parameter int WIDTH = 32
);
   logic               start;
   logic [WIDTH-1:0]   val;
   logic               ceil_mode;
   logic               busy;
   logic [WIDTH/2:0]   out;
   logic [WIDTH/2:0]   rem;
   logic               eop;

   modport master (
      output start, val, ceil_mode,
      input  busy, out, rem, eop
   );

   modport slave (
      input  start, val, ceil_mode,
      output busy, out, rem, eop
   );
endinterface

// File: rtl/sqrt_param.sv
// sqrt_param -- sequential restoring square root, one root bit per cycle.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : sqrt_param_if slave (start/val/ceil_mode in, busy/out/rem/eop out)
// Optional feature: define SQRT_CEIL_EN to compile in ceiling rounding.
// Without it ceil_mode is ignored and out is always the floor root.
//
// state | meaning
// IDLE  | waiting for start; out/rem hold last result
// CALC  | WIDTH/2 cycles, one root bit per cycle, MSB first
// DONE  | load out/rem, raise eop on the following cycle, return to IDLE
module sqrt_param #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   sqrt_param_if.slave  bus
);
   localparam int H  = WIDTH / 2;
   localparam int CW = $clog2(H + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(H);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rad_q, rad_d;
   logic [H-1:0]     root_q, root_d;
   logic [H:0]       acc_q, acc_d;
   logic [H:0]       out_q, out_d;
   logic [H:0]       rem_q, rem_d;
   logic             eop_q, eop_d;
`ifdef SQRT_CEIL_EN
   logic             ceil_q, ceil_d;
`endif

   // Trial subtraction: bring down the next two radicand bits and try
   // subtracting 4*root+1; keep the difference only if it does not go negative.
   logic [H+2:0] shifted;
   logic [H+2:0] trial;
   logic [H+2:0] diff;
   logic         fits;

   always_comb begin
      shifted = {acc_q, rad_q[WIDTH-1 -: 2]};
      trial   = {1'b0, root_q, 2'b01};
      diff    = shifted - trial;
      fits    = (shifted >= trial);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rad_d   = rad_q;
      root_d  = root_q;
      acc_d   = acc_q;
      out_d   = out_q;
      rem_d   = rem_q;
      eop_d   = 1'b0;
`ifdef SQRT_CEIL_EN
      ceil_d  = ceil_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               rad_d   = bus.val;
               root_d  = '0;
               acc_d   = '0;
               cnt_d   = CNT_LOAD;
`ifdef SQRT_CEIL_EN
               ceil_d  = bus.ceil_mode;
`endif
               state_d = CALC;
            end
         end
         CALC: begin
            rad_d  = {rad_q[WIDTH-3:0], 2'b00};
            root_d = {root_q[H-2:0], fits};
            acc_d  = fits ? diff[H:0] : shifted[H:0];
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CNT_LAST)
               state_d = DONE;
         end
         DONE: begin
`ifdef SQRT_CEIL_EN
            out_d = {1'b0, root_q} + (H+1)'(ceil_q && (acc_q != '0));
`else
            out_d = {1'b0, root_q};
`endif
            rem_d   = acc_q;
            eop_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rad_q   <= '0;
         root_q  <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         rem_q   <= '0;
         eop_q   <= 1'b0;
`ifdef SQRT_CEIL_EN
         ceil_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rad_q   <= rad_d;
         root_q  <= root_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         rem_q   <= rem_d;
         eop_q   <= eop_d;
`ifdef SQRT_CEIL_EN
         ceil_q  <= ceil_d;
`endif
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.out  = out_q;
   assign bus.rem  = rem_q;
   assign bus.eop  = eop_q;
endmodule

// File: tb/tb_sqrt_param.sv
module tb_sqrt_param;
   localparam int W   = 32;
   localparam int LAT = W/2 + 2;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   sqrt_param_if #(.WIDTH(W)) bus ();

   sqrt_param #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Single request; scrambles val/ceil_mode after acceptance.
   task automatic run(input string tag, input logic [W-1:0] v, input logic c,
                      input logic [W/2:0] e_out, input logic [W/2:0] e_rem);
      int   n;
      logic got;
      @(negedge clk);
      bus.val = v; bus.ceil_mode = c; bus.start = 1'b1;
      n = 0; got = 1'b0;
      while (n < 40 && !got) begin
         @(posedge clk); n++;
         @(negedge clk);
         bus.start = 1'b0; bus.val = ~v; bus.ceil_mode = ~c;
         if (n == 1) chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
         if (bus.eop) got = 1'b1;
      end
      chk({tag, "_lat"}, 64'(n), 64'(LAT));
      chk({tag, "_out"}, 64'(bus.out), 64'(e_out));
      chk({tag, "_rem"}, 64'(bus.rem), 64'(e_rem));
      @(negedge clk);
      chk({tag, "_eop1"}, 64'(bus.eop), 64'd0);
   endtask

   function automatic logic [W/2:0] cexp(input logic [W/2:0] fl, input logic [W/2:0] cl);
`ifdef SQRT_CEIL_EN
      return cl;
`else
      return fl;
`endif
   endfunction

   initial begin
      int n_eop;
      int t1;
      int t2;
      int n_low;
      n_cmp = 0; n_bad = 0;
      bus.start = 1'b0; bus.val = '0; bus.ceil_mode = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_eop",  64'(bus.eop),  64'd0);
      chk("rst_out",  64'(bus.out),  64'd0);
      chk("rst_rem",  64'(bus.rem),  64'd0);

      run("z0",  32'd0,  1'b0, 17'd0, 17'd0);
      run("z1",  32'd0,  1'b1, 17'd0, 17'd0);
      run("s16f", 32'd16, 1'b0, 17'd4, 17'd0);
      run("s16c", 32'd16, 1'b1, 17'd4, 17'd0);
      run("s17f", 32'd17, 1'b0, 17'd4, 17'd1);
      repeat (5) @(negedge clk);
      chk("hold_out", 64'(bus.out), 64'd4);
      chk("hold_rem", 64'(bus.rem), 64'd1);
      run("s17c", 32'd17, 1'b1, cexp(17'd4, 17'd5), 17'd1);
      run("s2c",  32'd2,  1'b1, cexp(17'd1, 17'd2), 17'd1);
      run("s15f", 32'd15, 1'b0, 17'd3, 17'd6);
      run("maxf", 32'hFFFF_FFFF, 1'b0, 17'd65535, 17'd131070);
      run("maxc", 32'hFFFF_FFFF, 1'b1, cexp(17'd65535, 17'd65536), 17'd131070);
      run("s1k",  32'd1000, 1'b0, 17'd31, 17'd39);

      // start during CALC must be ignored
      @(negedge clk);
      bus.val = 32'd100; bus.ceil_mode = 1'b0; bus.start = 1'b1;
      n_eop = 0; n_low = 0; t1 = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         @(negedge clk);
         bus.start = (i == 5);
         if (i == 5) bus.val = 32'd9;
         if (bus.eop) begin
            n_eop++;
            if (t1 == 0) begin
               t1 = i;
               chk("ign_out", 64'(bus.out), 64'd10);
               chk("ign_rem", 64'(bus.rem), 64'd0);
            end
         end
         if (t1 == 0 && !bus.busy) n_low++;
      end
      chk("ign_eops", 64'(n_eop), 64'd1);
      chk("ign_busy_low", 64'(n_low), 64'd0);

      // back-to-back with start held
      @(negedge clk);
      bus.val = 32'd16; bus.ceil_mode = 1'b0; bus.start = 1'b1;
      t1 = 0; t2 = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.eop) begin
            if (t1 == 0) t1 = i;
            else if (t2 == 0) t2 = i;
         end
      end
      bus.start = 1'b0;
      chk("b2b_first", 64'(t1), 64'(LAT));
      chk("b2b_period", 64'(t2 - t1), 64'(LAT));
      repeat (25) @(negedge clk);
      chk("b2b_idle", 64'(bus.busy), 64'd0);

      // reset mid-calculation
      @(negedge clk);
      bus.val = 32'd1000; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_out",  64'(bus.out),  64'd0);
      chk("arst_rem",  64'(bus.rem),  64'd0);
      @(negedge clk);
      rst = 1'b1;
      n_eop = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (bus.eop) n_eop++;
      end
      chk("arst_noeop", 64'(n_eop), 64'd0);
      run("post_rst", 32'd1000, 1'b0, 17'd31, 17'd39);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sqrt_param.md
SQRT_PARAM -- requirements
Module: sqrt_param

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the radicand width; legal values are even and at least 4.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a calculation, sampled on clk.
REQ-005 The module SHALL have port val, input, WIDTH bits: unsigned radicand, sampled when start is accepted.
REQ-006 The module SHALL have port ceil_mode, input, 1 bit: 0 selects floor rounding, 1 selects ceiling rounding; it is sampled with val.
REQ-007 The module SHALL have port busy, output, 1 bit: high while a calculation is in progress.
REQ-008 The module SHALL have port out, output, WIDTH/2+1 bits: the rounded square root.
REQ-009 The module SHALL have port rem, output, WIDTH/2+1 bits: val minus the square of the floor root.
REQ-010 The module SHALL have port eop, output, 1 bit: a one-cycle pulse marking that out and rem are valid.

Function
REQ-011 The state machine SHALL have three states: IDLE, CALC and DONE.
REQ-012 In IDLE, start=1 SHALL latch val and ceil_mode, clear the partial root and remainder, load the bit counter with WIDTH/2, and go to CALC.
REQ-013 CALC SHALL use restoring digit-by-digit square root: one root bit per cycle, MSB first, for exactly WIDTH/2 cycles, then go to DONE.
REQ-014 In DONE, out SHALL be loaded in one cycle:
  - floor root r when ceil_mode=0 or rem=0;
  - r+1 otherwise.
REQ-015 Also in DONE, rem SHALL be loaded, eop SHALL be 1 for exactly that one cycle, and the next state SHALL be IDLE.
REQ-016 Latency: if start is sampled at edge k, eop SHALL be high during the cycle after edge k+WIDTH/2+1.
REQ-017 A new start is accepted only in IDLE; with start held high, back-to-back operation SHALL give one result every WIDTH/2+2 cycles.
REQ-018 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-019 start asserted in CALC or DONE SHALL be ignored and SHALL NOT corrupt the latched operands.
REQ-020 Changes on val and ceil_mode after acceptance SHALL NOT affect the result in progress.
REQ-021 out and rem SHALL hold their last values until the next DONE cycle.
REQ-022 The out MSB SHALL be 1 only for the ceiling result 2^(WIDTH/2), that is, when the floor root is all ones and rem is nonzero.
REQ-023 val=0 SHALL give out=0 and rem=0 in both modes.

Reset
REQ-024 rst=0 SHALL immediately force state IDLE, busy=0, eop=0, out=0, rem=0, and clear all internal registers.
REQ-025 Reset asserted mid-calculation SHALL abort that calculation with no eop.
REQ-026 The first start sampled after rst deasserts SHALL be processed normally.

Configuration
REQ-027 Macro SQRT_CEIL_EN, when defined, SHALL compile in ceiling rounding per REQ-014.
REQ-028 When SQRT_CEIL_EN is undefined:
  - the ceil_mode port SHALL still exist but be ignored;
  - out SHALL always be the floor root;
  - the out MSB SHALL be constant 0;
  - the increment logic SHALL be absent.

Verification
REQ-029 WIDTH=32, val=0, ceil_mode=0 then 1 -> out=0, rem=0, eop pulsed once each, 18 cycles after start.
REQ-030 val=16 -> out=4, rem=0 in both modes; val=17 -> rem=1, with out=4 when ceil_mode=0 and out=5 when ceil_mode=1.
REQ-031 val=4294967295 -> ceil_mode=0 gives out=65535, rem=131070; ceil_mode=1 gives out=65536 (MSB set).
REQ-032 Start val=100, then pulse start with val=9 at cycle 5 -> only one eop, with out=10, rem=0; busy stays high throughout.
REQ-033 Start val=1000, assert rst at cycle 8 -> busy=0, out=0, rem=0 at once, no eop; then start val=1000 -> out=31, rem=39.
REQ-034 Without SQRT_CEIL_EN, val=17 with ceil_mode=1 -> out=4, rem=1.
